jk_bank_sequencer: RTL and testbench
====================================

# jk_bank_sequencer

Round-robin sequencer that shares one bank of `WIDTH` JK storage bits among `N_REQ` requesters. Each requester posts one J/K command (hold, reset, set or toggle) against a bit index. The block grants one command at a time and applies it with a single-cycle enable pulse, then holds a programmable settle gap before the next command. The single-cycle pulse prevents the toggle race-through that a level-held enable causes on JK latch cells. It sits between command sources (control FSMs, software register writes) and the JK bank, and it owns the bank's state.

## Interface
Parameters:
- `N_REQ`, 4: number of requesters (2..8).
- `WIDTH`, 8: number of JK bits in the bank.
- `IDX_W`, 3: bit-index width; must satisfy 2^IDX_W ≥ WIDTH.
- `GAP`, 2: idle settle cycles after each enable pulse (0..15).

Ports:
- `clk`  in  1  single clock; everything is sampled on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `req_valid`  in  N_REQ  per-requester command valid. Held high until the matching ack.
- `req_j`  in  N_REQ  J input of each requester's command.
- `req_k`  in  N_REQ  K input of each requester's command.
- `req_idx`  in  N_REQ*IDX_W  target bit index per requester; requester r uses slice [r*IDX_W +: IDX_W].
- `req_ack`  out  N_REQ  one-hot, single-cycle pulse: the command has been applied or dropped.
- `q`  out  WIDTH  bank state.
- `q_bar`  out  WIDTH  ~q, combinational.
- `en_pulse`  out  1  high for exactly the cycle in which a command is applied.
- `sel`  out  IDX_W  index of the bit being applied; valid when `en_pulse` is high.
- `err`  out  1  single-cycle pulse with the ack when the granted idx ≥ WIDTH.
- `busy`  out  1  high in ENABLE and SETTLE.

## Operation
- Reset (`rst` high at a clock edge):
  - `q` = 0.
  - `req_ack`, `en_pulse`, `err`, `busy` = 0; `sel` = 0.
  - Priority pointer = 0; FSM = IDLE.
  - Reset is honoured in any state. An in-flight command is discarded with no ack.
- FSM states: IDLE, ENABLE, SETTLE.
- IDLE:
  - If any `req_valid` is high, pick the winner by round-robin, starting at the priority pointer and wrapping modulo N_REQ.
  - Latch the winner's J, K and idx, then go to ENABLE. Otherwise stay in IDLE.
- ENABLE (exactly 1 cycle):
  - Assert `en_pulse`, drive `sel` = latched idx, and assert `req_ack[winner]`.
  - If idx < WIDTH, update q[idx] at the end of the cycle:
    - JK=00: hold.
    - JK=01: 0.
    - JK=10: 1.
    - JK=11: ~q[idx].
  - If idx ≥ WIDTH, `q` is unchanged and `err` pulses.
  - Set pointer = (winner+1) mod N_REQ.
  - Next state is SETTLE if GAP>0, otherwise IDLE.
- SETTLE:
  - Count down GAP cycles with no arbitration, then return to IDLE.
  - Requests arriving during SETTLE wait.
- A requester that keeps `req_valid` high after its ack is posting a new command. It competes again at the next IDLE at the lowest priority.
- Commands are latched at grant, so changes to `req_j`/`req_k`/`req_idx` after the IDLE grant edge have no effect.
- Toggle is applied exactly once per grant, regardless of enable width seen downstream.

## Timing
- Request-to-ack latency when idle: the grant is taken at edge t; `req_ack`/`en_pulse` are high in cycle t..t+1; the new `q` is visible after edge t+1.
- Command period: 2+GAP cycles per command (IDLE, ENABLE, GAP×SETTLE). Maximum throughput is 1/(2+GAP).
- `req_ack`, `en_pulse`, `sel` and `err` are registered outputs with no combinational path from `req_*`. `q_bar` is combinational from `q` only.
- Round-robin fairness: with all N_REQ requesters continuously valid, each is granted exactly once every N_REQ commands.

## Test plan
- Reset, then requester 0 sends J=1 K=0 idx=3 → ack[0] and en_pulse high in the 2nd cycle after valid, sel=3; afterwards q=8'h08, q_bar=8'hF7, busy high for 1+GAP cycles.
- With q[5]=1, requester 2 sends JK=11 idx=5, held valid through the ack and then dropped → q[5]=0 after exactly one toggle; a second JK=11 grant gives q[5]=1.
- All 4 requesters valid continuously, GAP=2 → acks in order 0,1,2,3,0,…, spaced 4 cycles apart, one-hot every time.
- Requester 1 sends idx=9 with WIDTH=8 → ack[1] and err pulse in the same cycle; q unchanged.
- `rst` asserted in the ENABLE cycle of a JK=10 idx=0 command → q=0, no ack, FSM in IDLE, pointer=0 on the next cycle.
- GAP=0, requester 3 continuously valid with JK=00 → en_pulse every other cycle; q stays at its prior value.

Source files
------------

// File: rtl/jk_bank_sequencer.sv
// Round-robin sequencer that applies one J/K command at a time to a shared JK bank,
// using a single-cycle enable pulse followed by a programmable settle gap.
module jk_bank_sequencer #(
  parameter int N_REQ = 4,
  parameter int WIDTH = 8,
  parameter int IDX_W = 3,
  parameter int GAP   = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [N_REQ-1:0]         req_valid,
  input  logic [N_REQ-1:0]         req_j,
  input  logic [N_REQ-1:0]         req_k,
  input  logic [N_REQ*IDX_W-1:0]   req_idx,
  output logic [N_REQ-1:0]         req_ack,
  output logic [WIDTH-1:0]         q,
  output logic [WIDTH-1:0]         q_bar,
  output logic                     en_pulse,
  output logic [IDX_W-1:0]         sel,
  output logic                     err,
  output logic                     busy
);
  localparam int PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam logic [3:0] GAP_LD = (GAP > 0) ? 4'(GAP - 1) : 4'd0;

  typedef enum logic [1:0] {IDLE, ENABLE, SETTLE} state_t;

  state_t           state;
  logic [PW-1:0]    ptr, win, grant_id;
  logic             grant_any;
  logic             lat_j, lat_k;
  logic [IDX_W-1:0] lat_idx, grant_idx;
  logic [3:0]       cnt;

  assign q_bar = ~q;

  // Scan from the highest offset down so the lowest offset from ptr wins.
  always_comb begin
    int c;
    c = 0;
    grant_any = |req_valid;
    grant_id  = '0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      c = int'(ptr) + i;
      if (c >= N_REQ) c = c - N_REQ;
      if (req_valid[c]) grant_id = PW'(c);
    end
    grant_idx = req_idx[int'(grant_id)*IDX_W +: IDX_W];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      q        <= '0;
      req_ack  <= '0;
      en_pulse <= 1'b0;
      err      <= 1'b0;
      busy     <= 1'b0;
      sel      <= '0;
      ptr      <= '0;
      win      <= '0;
      lat_j    <= 1'b0;
      lat_k    <= 1'b0;
      lat_idx  <= '0;
      cnt      <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (grant_any) begin
            win      <= grant_id;
            lat_j    <= req_j[grant_id];
            lat_k    <= req_k[grant_id];
            lat_idx  <= grant_idx;
            sel      <= grant_idx;
            en_pulse <= 1'b1;
            req_ack  <= N_REQ'(1) << grant_id;
            err      <= (int'(grant_idx) >= WIDTH);
            busy     <= 1'b1;
            state    <= ENABLE;
          end
        end
        ENABLE: begin
          en_pulse <= 1'b0;
          req_ack  <= '0;
          err      <= 1'b0;
          ptr      <= (win == PW'(N_REQ - 1)) ? '0 : win + PW'(1);
          // Out-of-range commands are acked with err but leave the bank alone.
          if (int'(lat_idx) < WIDTH) begin
            case ({lat_j, lat_k})
              2'b01:   q[lat_idx] <= 1'b0;
              2'b10:   q[lat_idx] <= 1'b1;
              2'b11:   q[lat_idx] <= ~q[lat_idx];
              default: ;
            endcase
          end
          if (GAP > 0) begin
            state <= SETTLE;
            cnt   <= GAP_LD;
          end else begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        end
        SETTLE: begin
          if (cnt == 4'd0) begin
            state <= IDLE;
            busy  <= 1'b0;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_jk_bank_sequencer.sv
// Directed bench: expected grants queued at issue time, popped on each en_pulse.
module tb_jk_bank_sequencer;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Instance A: GAP=2, IDX_W=4 so out-of-range indices can be posted.
  logic        a_rst;
  logic [3:0]  a_valid, a_j, a_k, a_ack;
  logic [15:0] a_idx;
  logic [7:0]  a_q, a_qb;
  logic        a_en, a_err, a_busy;
  logic [3:0]  a_sel;

  // Instance B: GAP=0, default IDX_W.
  logic        b_rst;
  logic [3:0]  b_valid, b_j, b_k, b_ack;
  logic [11:0] b_idx;
  logic [7:0]  b_q, b_qb;
  logic        b_en, b_err, b_busy;
  logic [2:0]  b_sel;

  jk_bank_sequencer #(.N_REQ(4), .WIDTH(8), .IDX_W(4), .GAP(2)) dut_a (
    .clk(clk), .rst(a_rst), .req_valid(a_valid), .req_j(a_j), .req_k(a_k),
    .req_idx(a_idx), .req_ack(a_ack), .q(a_q), .q_bar(a_qb), .en_pulse(a_en),
    .sel(a_sel), .err(a_err), .busy(a_busy));

  jk_bank_sequencer #(.N_REQ(4), .WIDTH(8), .IDX_W(3), .GAP(0)) dut_b (
    .clk(clk), .rst(b_rst), .req_valid(b_valid), .req_j(b_j), .req_k(b_k),
    .req_idx(b_idx), .req_ack(b_ack), .q(b_q), .q_bar(b_qb), .en_pulse(b_en),
    .sel(b_sel), .err(b_err), .busy(b_busy));

  typedef struct {
    logic [3:0] ack;
    logic [3:0] sel;
    logic       err;
  } exp_t;

  exp_t       sb[$];
  logic [7:0] q_m;
  int         checks = 0;
  int         failures = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Post a command on A (call at a negedge) and queue its expected grant.
  task automatic issue(input int r, input logic j, input logic k, input logic [3:0] idx);
    exp_t e;
    a_valid[r] = 1'b1;
    a_j[r] = j;
    a_k[r] = k;
    a_idx[r*4 +: 4] = idx;
    e.ack = 4'(1 << r);
    e.sel = idx;
    e.err = (idx >= 4'd8);
    sb.push_back(e);
    if (idx < 4'd8) begin
      case ({j, k})
        2'b01:   q_m[idx[2:0]] = 1'b0;
        2'b10:   q_m[idx[2:0]] = 1'b1;
        2'b11:   q_m[idx[2:0]] = ~q_m[idx[2:0]];
        default: ;
      endcase
    end
  endtask

  task automatic wait_ack(input string tag, output int n);
    exp_t e;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!a_en && n < 50);
    if (!a_en) chk({tag, "_timeout"}, 32'(a_en), 32'd1);
    else if (sb.size() == 0) chk({tag, "_spurious"}, 32'(sb.size()), 32'd1);
    else begin
      e = sb.pop_front();
      chk({tag, "_ack"}, 32'(a_ack), 32'(e.ack));
      chk({tag, "_sel"}, 32'(a_sel), 32'(e.sel));
      chk({tag, "_err"}, 32'(a_err), 32'(e.err));
    end
  endtask

  task automatic wait_idle(output int bc);
    bc = 0;
    while (a_busy && bc < 40) begin
      bc++;
      @(negedge clk);
    end
  endtask

  initial begin
    int n, bc;
    a_rst = 1'b1; a_valid = '0; a_j = '0; a_k = '0; a_idx = '0;
    b_rst = 1'b1; b_valid = '0; b_j = '0; b_k = '0; b_idx = '0;
    q_m = '0;
    repeat (2) @(negedge clk);
    chk("rst_q", 32'(a_q), 32'h00);
    chk("rst_qbar", 32'(a_qb), 32'hFF);
    chk("rst_ack", 32'(a_ack), 32'h0);
    chk("rst_en", 32'(a_en), 32'h0);
    chk("rst_busy", 32'(a_busy), 32'h0);
    chk("rst_err", 32'(a_err), 32'h0);
    chk("rst_sel", 32'(a_sel), 32'h0);
    a_rst = 1'b0;
    @(negedge clk);

    // Set bit 3; ack arrives one edge after valid, busy lasts 1+GAP cycles.
    issue(0, 1'b1, 1'b0, 4'd3);
    wait_ack("t1", n);
    chk("t1_latency", 32'(n), 32'd1);
    a_valid[0] = 1'b0;
    wait_idle(bc);
    chk("t1_busy_len", 32'(bc), 32'd3);
    chk("t1_q", 32'(a_q), 32'(q_m));
    chk("t1_q_exp", 32'(a_q), 32'h08);
    chk("t1_qbar", 32'(a_qb), 32'hF7);

    // Toggle applied exactly once per grant.
    issue(2, 1'b1, 1'b0, 4'd5);
    wait_ack("t2_set", n);
    a_valid[2] = 1'b0;
    wait_idle(bc);
    chk("t2_set_q", 32'(a_q), 32'h28);
    issue(2, 1'b1, 1'b1, 4'd5);
    wait_ack("t2_tog1", n);
    a_valid[2] = 1'b0;
    wait_idle(bc);
    chk("t2_tog1_q", 32'(a_q), 32'(q_m));
    chk("t2_tog1_bit", 32'(a_q[5]), 32'd0);
    issue(2, 1'b1, 1'b1, 4'd5);
    wait_ack("t2_tog2", n);
    a_valid[2] = 1'b0;
    wait_idle(bc);
    chk("t2_tog2_bit", 32'(a_q[5]), 32'd1);

    // Out-of-range index: ack with err, bank untouched.
    issue(1, 1'b1, 1'b0, 4'd9);
    wait_ack("t4", n);
    a_valid[1] = 1'b0;
    wait_idle(bc);
    chk("t4_q", 32'(a_q), 32'(q_m));

    // Reset during ENABLE discards the command with no ack.
    a_valid[0] = 1'b1; a_j[0] = 1'b1; a_k[0] = 1'b0; a_idx[3:0] = 4'd0;
    n = 0;
    do begin @(negedge clk); n++; end while (!a_en && n < 20);
    chk("t5_reached_enable", 32'(a_en), 32'd1);
    a_rst = 1'b1;
    a_valid = '0;
    @(negedge clk);
    a_rst = 1'b0;
    q_m = '0;
    chk("t5_q", 32'(a_q), 32'h00);
    chk("t5_ack", 32'(a_ack), 32'h0);
    chk("t5_en", 32'(a_en), 32'h0);
    chk("t5_busy", 32'(a_busy), 32'h0);
    repeat (3) begin
      @(negedge clk);
      chk("t5_no_late_ack", 32'(a_ack), 32'h0);
    end

    // All requesters valid: pointer restarts at 0, strict rotation, 4 cycles apart.
    for (int r = 0; r < 4; r++) issue(r, 1'b0, 1'b0, 4'(r));
    for (int r = 0; r < 4; r++) issue(r, 1'b0, 1'b0, 4'(r));
    for (int i = 0; i < 8; i++) begin
      wait_ack("t3", n);
      chk("t3_onehot", 32'($onehot(a_ack)), 32'd1);
      chk("t3_spacing", 32'(n), (i == 0) ? 32'd1 : 32'd4);
    end
    a_valid = '0;
    wait_idle(bc);
    chk("t3_q", 32'(a_q), 32'h00);
    chk("t3_sb_empty", 32'(sb.size()), 32'd0);

    // GAP=0: continuous hold commands pulse every other cycle.
    b_rst = 1'b0;
    b_valid[3] = 1'b1; b_j[3] = 1'b1; b_k[3] = 1'b0; b_idx[11:9] = 3'd2;
    n = 0;
    do begin @(negedge clk); n++; end while (!b_en && n < 20);
    chk("t6_first_en", 32'(b_en), 32'd1);
    b_j[3] = 1'b0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      chk("t6_en", 32'(b_en), 32'(c % 2));
      chk("t6_ack", 32'(b_ack), (c % 2) ? 32'h8 : 32'h0);
      chk("t6_q", 32'(b_q), 32'h04);
    end
    b_valid = '0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
